branch_unit: RTL and testbench

Branch resolution unit for the pipelined core. It extends the single-cycle brancher with three additions: a PC-indexed table of saturating counters that gives fetch a taken/not-taken prediction, registered misprediction detection and redirect in execute, and performance counters. The block sits between fetch (predict port) and execute (resolve port). It owns the redirect/flush decision for all control-transfer instructions.

---
 rtl/branch_unit_if.sv | 35 +++
 rtl/branch_unit.sv | 112 +++++++++++
 tb/tb_branch_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/branch_unit_if.sv
// Fetch-predict and execute-resolve signals of the branch unit, bundled with
// the redirect and statistics outputs it returns to the pipeline.
interface branch_unit_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0] pred_pc;
   logic          pred_taken;
   logic          ex_valid;
   logic [AW-1:0] ex_pc;
   logic [DW-1:0] ex_imm;
   logic          ex_pred_taken;
   logic          is_b_type;
   logic          is_jal;
   logic          is_jalr;
   logic [2:0]    func3;
   logic [DW-1:0] rs1_data;
   logic [DW-1:0] rs2_data;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic [31:0]   stat_branches;
   logic [31:0]   stat_mispred;

   modport master (
      output pred_pc, ex_valid, ex_pc, ex_imm, ex_pred_taken,
             is_b_type, is_jal, is_jalr, func3, rs1_data, rs2_data,
      input  pred_taken, redirect_valid, redirect_pc, stat_branches, stat_mispred
   );

   modport slave (
      input  pred_pc, ex_valid, ex_pc, ex_imm, ex_pred_taken,
             is_b_type, is_jal, is_jalr, func3, rs1_data, rs2_data,
      output pred_taken, redirect_valid, redirect_pc, stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution unit: PC-indexed saturating-counter predictor for fetch,
// registered mispredict detection/redirect for execute, and perf counters.
module branch_unit #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_W       = 2
) (
   input logic        clk,
   input logic        rst_n,
   branch_unit_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;

   logic [CTR_W-1:0] bht [BHT_ENTRIES];

   logic             redirect_q;
   logic [AW-1:0]    redirect_pc_q;
   logic [31:0]      stat_br_q;
   logic [31:0]      stat_mis_q;

   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             res;
   logic             taken;
   logic             cond_ok;
   logic             mispred;
   logic             ctr_upd;
   logic [CTR_W-1:0] ctr_cur;
   logic [CTR_W-1:0] ctr_next;
   logic [AW-1:0]    imm_aw;
   logic [DW-1:0]    jalr_sum;
   logic [AW-1:0]    target;
   logic [AW-1:0]    fall_pc;
   logic [AW-1:0]    next_pc;

   assign pred_idx       = bus.pred_pc[IDX_W+1:2];
   assign ex_idx         = bus.ex_pc[IDX_W+1:2];
   assign bus.pred_taken = bht[pred_idx][CTR_W-1];

   // The instruction behind a redirect is wrong-path and must leave no trace.
   assign res = bus.ex_valid & ~redirect_q & (bus.is_b_type | bus.is_jal | bus.is_jalr);

   assign imm_aw   = AW'($signed(bus.ex_imm));
   assign jalr_sum = bus.rs1_data + bus.ex_imm;
   assign fall_pc  = bus.ex_pc + AW'(4);
   assign target   = bus.is_jalr ? (AW'(jalr_sum) & ~AW'(1)) : (bus.ex_pc + imm_aw);
   assign next_pc  = taken ? target : fall_pc;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave it unassigned and infer a latch.
      taken   = 1'b0;
      cond_ok = 1'b0;
      if (bus.is_jal || bus.is_jalr) begin
         taken = 1'b1;
      end else begin
         case (bus.func3)
            3'b000: begin taken = (bus.rs1_data == bus.rs2_data);                  cond_ok = 1'b1; end
            3'b001: begin taken = (bus.rs1_data != bus.rs2_data);                  cond_ok = 1'b1; end
            3'b100: begin taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data)); cond_ok = 1'b1; end
            3'b101: begin taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data)); cond_ok = 1'b1; end
            3'b110: begin taken = (bus.rs1_data <  bus.rs2_data);                   cond_ok = 1'b1; end
            3'b111: begin taken = (bus.rs1_data >= bus.rs2_data);                   cond_ok = 1'b1; end
            default: ;
         endcase
      end
   end

   // jalr has no predicted target, so it always redirects.
   assign mispred = res & (bus.is_jalr |
                           (bus.is_jal & ~bus.ex_pred_taken) |
                           (bus.is_b_type & (taken != bus.ex_pred_taken)));
   assign ctr_upd = res & bus.is_b_type & cond_ok;

   always_comb begin
      ctr_cur  = bht[ex_idx];
      ctr_next = ctr_cur;
      if (taken) begin
         if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_W'(1);
      end else if (ctr_cur != '0) begin
         ctr_next = ctr_cur - CTR_W'(1);
      end
   end

   // NOTE: non-blocking assignments throughout, so every flop samples the
   // pre-edge values and same-cycle reads see the old table entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         stat_br_q     <= '0;
         stat_mis_q    <= '0;
         // NOTE: the table is deliberately reset; its initial contents define
         // the first predictions, so it cannot be left to power-up values.
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
      end else begin
         redirect_q <= mispred;
         if (mispred) redirect_pc_q <= next_pc;
         if (res)     stat_br_q     <= stat_br_q + 32'd1;
         if (mispred) stat_mis_q    <= stat_mis_q + 32'd1;
         if (ctr_upd) bht[ex_idx]   <= ctr_next;
      end
   end

   assign bus.redirect_valid = redirect_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.stat_branches  = stat_br_q;
   assign bus.stat_mispred   = stat_mis_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a table of resolve vectors with hand-computed
// redirect/stat/prediction results, plus sequences for masking and reset.
module tb_branch_unit;
   typedef enum logic [1:0] {K_B, K_JAL, K_JALR} kind_e;

   typedef struct {
      kind_e       kind;
      logic [2:0]  f3;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        pt;
      logic        exp_rv;
      logic [31:0] exp_rpc;
      logic [31:0] exp_br;
      logic [31:0] exp_mis;
      logic [31:0] chk_pc;
      logic        exp_pt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   vec_t vecs [18];

   always #5 clk = ~clk;

   branch_unit_if #(.AW(32), .DW(32)) bus ();

   branch_unit #(.AW(32), .DW(32), .BHT_ENTRIES(64), .CTR_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk(input kind_e k, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic pt, input logic rv, input logic [31:0] rpc,
                               input logic [31:0] br, input logic [31:0] mis,
                               input logic [31:0] cpc, input logic ept);
      vec_t v;
      v.kind = k; v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.pt = pt;
      v.exp_rv = rv; v.exp_rpc = rpc; v.exp_br = br; v.exp_mis = mis;
      v.chk_pc = cpc; v.exp_pt = ept;
      return v;
   endfunction

   task automatic drive(input kind_e k, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic pt);
      bus.ex_valid      = 1'b1;
      bus.is_b_type     = (k == K_B);
      bus.is_jal        = (k == K_JAL);
      bus.is_jalr       = (k == K_JALR);
      bus.func3         = f3;
      bus.ex_pc         = pc;
      bus.ex_imm        = imm;
      bus.rs1_data      = rs1;
      bus.rs2_data      = rs2;
      bus.ex_pred_taken = pt;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      drive(v.kind, v.f3, v.pc, v.imm, v.rs1, v.rs2, v.pt);
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      bus.pred_pc  = v.chk_pc;
      #1;
      check($sformatf("v%0d redirect_valid", i), {31'd0, bus.redirect_valid}, {31'd0, v.exp_rv});
      check($sformatf("v%0d redirect_pc", i), bus.redirect_pc, v.exp_rpc);
      check($sformatf("v%0d stat_branches", i), bus.stat_branches, v.exp_br);
      check($sformatf("v%0d stat_mispred", i), bus.stat_mispred, v.exp_mis);
      check($sformatf("v%0d pred_taken", i), {31'd0, bus.pred_taken}, {31'd0, v.exp_pt});
      @(posedge clk); #1;
      check($sformatf("v%0d redirect_drop", i), {31'd0, bus.redirect_valid}, 32'd0);
      check($sformatf("v%0d redirect_pc_hold", i), bus.redirect_pc, v.exp_rpc);
   endtask

   initial begin
      vecs[0]  = mk(K_B,    3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 1'b1, 32'h140, 32'd1,  32'd1,  32'h100, 1'b1);
      vecs[1]  = mk(K_B,    3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b1, 1'b0, 32'h140, 32'd2,  32'd1,  32'h200, 1'b1);
      vecs[2]  = mk(K_B,    3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b1, 1'b0, 32'h140, 32'd3,  32'd1,  32'h100, 1'b1);
      vecs[3]  = mk(K_B,    3'b000, 32'h100, 32'h40, 32'd5, 32'd6, 1'b1, 1'b1, 32'h104, 32'd4,  32'd2,  32'h100, 1'b1);
      vecs[4]  = mk(K_B,    3'b001, 32'h100, 32'h40, 32'd5, 32'd5, 1'b1, 1'b1, 32'h104, 32'd5,  32'd3,  32'h100, 1'b0);
      vecs[5]  = mk(K_B,    3'b001, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 1'b0, 32'h104, 32'd6,  32'd3,  32'h100, 1'b0);
      vecs[6]  = mk(K_B,    3'b001, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 1'b0, 32'h104, 32'd7,  32'd3,  32'h100, 1'b0);
      vecs[7]  = mk(K_B,    3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 1'b1, 32'h140, 32'd8,  32'd4,  32'h100, 1'b0);
      vecs[8]  = mk(K_B,    3'b100, 32'h304, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h324, 32'd9,  32'd5, 32'h304, 1'b1);
      vecs[9]  = mk(K_B,    3'b110, 32'h304, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'h308, 32'd10, 32'd6, 32'h304, 1'b0);
      vecs[10] = mk(K_B,    3'b101, 32'h308, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h308, 32'd11, 32'd6, 32'h308, 1'b0);
      vecs[11] = mk(K_B,    3'b111, 32'h30C, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'h308, 32'd12, 32'd6, 32'h30C, 1'b1);
      vecs[12] = mk(K_B,    3'b011, 32'h10C, 32'h40, 32'd0, 32'd0, 1'b0, 1'b0, 32'h308, 32'd13, 32'd6,  32'h30C, 1'b1);
      vecs[13] = mk(K_JALR, 3'b000, 32'h400, 32'h4,  32'h203, 32'd0, 1'b1, 1'b1, 32'h206, 32'd14, 32'd7, 32'h100, 1'b0);
      vecs[14] = mk(K_JAL,  3'b000, 32'h500, 32'h80, 32'd0, 32'd0, 1'b1, 1'b0, 32'h206, 32'd15, 32'd7,  32'h500, 1'b0);
      vecs[15] = mk(K_JAL,  3'b000, 32'h500, 32'h80, 32'd0, 32'd0, 1'b0, 1'b1, 32'h580, 32'd16, 32'd8,  32'h500, 1'b0);
      vecs[16] = mk(K_B,    3'b001, 32'hFFFF_FFFC, 32'h40, 32'd5, 32'd5, 1'b1, 1'b1, 32'h0,  32'd17, 32'd9,  32'hFFFF_FFFC, 1'b0);
      vecs[17] = mk(K_B,    3'b000, 32'hFFFF_FFF0, 32'h20, 32'd5, 32'd5, 1'b0, 1'b1, 32'h10, 32'd18, 32'd10, 32'h0000_00F0, 1'b1);

      rst_n = 1'b0;
      bus.pred_pc = '0;
      drive(K_B, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      bus.ex_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      check("reset redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
      check("reset redirect_pc", bus.redirect_pc, 32'd0);
      check("reset stat_branches", bus.stat_branches, 32'd0);
      check("reset stat_mispred", bus.stat_mispred, 32'd0);
      bus.pred_pc = 32'h100;        #1; check("reset pred 0x100", {31'd0, bus.pred_taken}, 32'd0);
      bus.pred_pc = 32'hFFFF_FFFC;  #1; check("reset pred 0xFFFFFFFC", {31'd0, bus.pred_taken}, 32'd0);

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // Same-cycle read returns the old counter, then the next branch is masked.
      drive(K_B, 3'b000, 32'h0, 32'h40, 32'd5, 32'd5, 1'b0);
      bus.pred_pc = 32'h0;
      #1;
      check("pre-update pred", {31'd0, bus.pred_taken}, 32'd0);
      @(posedge clk); #1;
      check("mask N+1 redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
      check("mask N+1 redirect_pc", bus.redirect_pc, 32'h40);
      check("post-update pred", {31'd0, bus.pred_taken}, 32'd1);
      drive(K_B, 3'b001, 32'h0, 32'h40, 32'd5, 32'd5, 1'b1);
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      #1;
      check("mask N+2 redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
      check("mask N+2 redirect_pc", bus.redirect_pc, 32'h40);
      check("mask stat_branches", bus.stat_branches, 32'd19);
      check("mask stat_mispred", bus.stat_mispred, 32'd11);
      check("mask counter untouched", {31'd0, bus.pred_taken}, 32'd1);

      // Reset coinciding with a mispredicting jalr discards it.
      drive(K_JALR, 3'b000, 32'h600, 32'h0, 32'h800, 32'd0, 1'b1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("rst+resolve redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
      check("rst+resolve redirect_pc", bus.redirect_pc, 32'd0);
      check("rst+resolve stat_branches", bus.stat_branches, 32'd0);
      check("rst+resolve stat_mispred", bus.stat_mispred, 32'd0);
      check("rst+resolve pred 0x0", {31'd0, bus.pred_taken}, 32'd0);
      bus.pred_pc = 32'h0000_00F0; #1;
      check("rst+resolve pred 0xF0", {31'd0, bus.pred_taken}, 32'd0);
      @(posedge clk); #1;
      check("after reset redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
